// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } e_tx_state;

    localparam int data_bits = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Counts clocks within one serial bit and pulses o_bit_done on the last clock of each bit.
module uart_bit_timer #(
    parameter int cycles_per_bit = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    output logic o_bit_done
);

    localparam int CW = $clog2(cycles_per_bit);
    localparam logic [CW-1:0] LAST_COUNT = CW'(cycles_per_bit - 1);

    logic [CW-1:0] r_count;

    // Held at zero while disabled so the first bit after leaving IDLE gets full width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_enable || r_count == LAST_COUNT) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_bit_done = i_enable && (r_count == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding an 8N1(+extra stop) shifter.
module uart_tx
    import uart_pkg::*;
#(
    parameter int cycles_per_bit  = 4,
    parameter int extra_stop_bits = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_req,
    output logic       o_serial,
    output logic       o_cts,
    output logic       o_idle
);

    localparam int SW = (extra_stop_bits > 0) ? $clog2(extra_stop_bits + 1) : 1;
    localparam logic [SW-1:0] LAST_STOP = SW'(extra_stop_bits);
    localparam logic [2:0]    LAST_DATA = 3'(data_bits - 1);

    e_tx_state     r_state;
    e_tx_state     w_next_state;
    logic [2:0]    r_bit_cnt;
    logic [SW-1:0] r_stop_cnt;
    logic          r_hold_full;
    logic [7:0]    r_hold_data;
    logic [7:0]    r_shift;
    logic          r_serial;
    logic          w_serial_next;
    logic          w_bit_done;
    logic          w_last_stop;
    logic          w_last_data;
    logic          w_accept;
    logic          w_transfer;

    uart_bit_timer #(
        .cycles_per_bit(cycles_per_bit)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_enable  (r_state != IDLE),
        .o_bit_done(w_bit_done)
    );

    assign w_last_stop = (r_stop_cnt == LAST_STOP);
    assign w_last_data = (r_bit_cnt == LAST_DATA);
    assign w_accept    = i_req && !r_hold_full;
    // Accept needs an empty holding register, transfer needs a full one: never the same edge.
    assign w_transfer  = r_hold_full &&
                         ((r_state == IDLE) || (r_state == STOP && w_bit_done && w_last_stop));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= '0;
            r_hold_full <= 1'b0;
            r_serial    <= 1'b1;
        end else begin
            r_state  <= w_next_state;
            r_serial <= w_serial_next;
            if (r_state == DATA && w_bit_done) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (r_state == STOP && w_bit_done) begin
                r_stop_cnt <= w_last_stop ? '0 : r_stop_cnt + 1'b1;
            end
            if (w_accept) begin
                r_hold_full <= 1'b1;
            end else if (w_transfer) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold_data <= i_data;
        end
        if (w_transfer) begin
            r_shift <= r_hold_data;
        end else if (r_state == DATA && w_bit_done) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_transfer) w_next_state = START;
            START:   if (w_bit_done) w_next_state = DATA;
            DATA:    if (w_bit_done && w_last_data) w_next_state = STOP;
            STOP:    if (w_bit_done && w_last_stop) w_next_state = w_transfer ? START : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The line value is computed one clock ahead so o_serial comes straight from a flop.
    always_comb begin
        w_serial_next = r_serial;
        o_cts         = !r_hold_full;
        o_idle        = (r_state == IDLE) && !r_hold_full;
        if (w_transfer) begin
            w_serial_next = 1'b0;
        end else begin
            case (r_state)
                START:   if (w_bit_done) w_serial_next = r_shift[0];
                DATA:    if (w_bit_done) w_serial_next = w_last_data ? 1'b1 : r_shift[1];
                STOP:    if (w_bit_done) w_serial_next = 1'b1;
                default: w_serial_next = 1'b1;
            endcase
        end
    end

    assign o_serial = r_serial;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default, extra-stop-bit and fast-bit-rate instances.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       req = 1'b0;
    int         sel = 0;

    logic serialA, ctsA, idleA;
    logic serialB, ctsB, idleB;
    logic serialC, ctsC, idleC;
    logic obsSerial, obsCts, obsIdle;
    logic reqA, reqB, reqC;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    assign reqA = req && (sel == 0);
    assign reqB = req && (sel == 1);
    assign reqC = req && (sel == 2);

    uart_tx #(.cycles_per_bit(4), .extra_stop_bits(0)) dutA (
        .clk(clk), .rst_n(rst_n), .i_data(data), .i_req(reqA),
        .o_serial(serialA), .o_cts(ctsA), .o_idle(idleA)
    );

    uart_tx #(.cycles_per_bit(4), .extra_stop_bits(1)) dutB (
        .clk(clk), .rst_n(rst_n), .i_data(data), .i_req(reqB),
        .o_serial(serialB), .o_cts(ctsB), .o_idle(idleB)
    );

    uart_tx #(.cycles_per_bit(2), .extra_stop_bits(0)) dutC (
        .clk(clk), .rst_n(rst_n), .i_data(data), .i_req(reqC),
        .o_serial(serialC), .o_cts(ctsC), .o_idle(idleC)
    );

    always_comb begin
        obsSerial = serialA;
        obsCts    = ctsA;
        obsIdle   = idleA;
        if (sel == 1) begin
            obsSerial = serialB;
            obsCts    = ctsB;
            obsIdle   = idleB;
        end else if (sel == 2) begin
            obsSerial = serialC;
            obsCts    = ctsC;
            obsIdle   = idleC;
        end
    end

    function automatic logic expectedBit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [7:0] d);
        req  = r;
        data = d;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Accept a byte on an idle instance and check every clock of its frame.
    task automatic runFrame(input int which, input logic [7:0] d, input int cpb,
                            input int extra, input string name);
        sel = which;
        applyStimulus(1'b1, d);
        tick();
        checkOutput({name, " cts after accept"}, 8'(obsCts), 8'd0);
        checkOutput({name, " idle after accept"}, 8'(obsIdle), 8'd0);
        checkOutput({name, " serial before start"}, 8'(obsSerial), 8'd1);
        applyStimulus(1'b0, d);
        tick();
        for (int i = 0; i < (10 + extra) * cpb; i++) begin
            checkOutput($sformatf("%s clk %0d", name, i), 8'(obsSerial),
                        8'(expectedBit(d, i / cpb)));
            tick();
        end
        checkOutput({name, " idle after frame"}, 8'(obsIdle), 8'd1);
        checkOutput({name, " serial after frame"}, 8'(obsSerial), 8'd1);
        checkOutput({name, " cts after frame"}, 8'(obsCts), 8'd1);
    endtask

    initial begin
        applyStimulus(1'b0, 8'h00);
        rst_n = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput($sformatf("reset dut%0d serial", s), 8'(obsSerial), 8'd1);
            checkOutput($sformatf("reset dut%0d cts", s), 8'(obsCts), 8'd1);
            checkOutput($sformatf("reset dut%0d idle", s), 8'(obsIdle), 8'd1);
        end
        rst_n = 1'b1;
        tick();

        runFrame(0, 8'h55, 4, 0, "frame55");
        runFrame(0, 8'hA3, 4, 0, "frameA3");

        // Back-to-back 0x48 / 0x65 with a 0xFF request ignored while the holding register is full.
        sel = 0;
        applyStimulus(1'b1, 8'h48);
        tick();
        checkOutput("b2b cts after first accept", 8'(obsCts), 8'd0);
        applyStimulus(1'b1, 8'h65);
        tick();
        for (int i = 0; i < 80; i++) begin
            if (i == 0) checkOutput("b2b cts after first transfer", 8'(obsCts), 8'd1);
            if (i == 1) begin
                checkOutput("b2b cts after second accept", 8'(obsCts), 8'd0);
                applyStimulus(1'b0, 8'h65);
            end
            if (i == 10) applyStimulus(1'b1, 8'hFF);
            if (i == 11) begin
                checkOutput("b2b cts after ignored req", 8'(obsCts), 8'd0);
                applyStimulus(1'b0, 8'hFF);
            end
            if (i == 40) checkOutput("b2b cts after second transfer", 8'(obsCts), 8'd1);
            checkOutput($sformatf("b2b clk %0d", i), 8'(obsSerial),
                        8'(i < 40 ? expectedBit(8'h48, i / 4) : expectedBit(8'h65, (i - 40) / 4)));
            tick();
        end
        checkOutput("b2b idle after frames", 8'(obsIdle), 8'd1);
        checkOutput("b2b serial after frames", 8'(obsSerial), 8'd1);

        // Reset during data bit 3 of 0xA5 while 0x3C waits in the holding register.
        applyStimulus(1'b1, 8'hA5);
        tick();
        applyStimulus(1'b1, 8'h3C);
        tick();
        for (int i = 0; i < 18; i++) begin
            if (i == 1) begin
                checkOutput("abort cts with byte held", 8'(obsCts), 8'd0);
                applyStimulus(1'b0, 8'h3C);
            end
            checkOutput($sformatf("abort clk %0d", i), 8'(obsSerial),
                        8'(expectedBit(8'hA5, i / 4)));
            tick();
        end
        checkOutput("abort serial in bit 3", 8'(obsSerial), 8'd0);
        rst_n = 1'b0;
        tick();
        checkOutput("abort serial after reset", 8'(obsSerial), 8'd1);
        checkOutput("abort cts after reset", 8'(obsCts), 8'd1);
        checkOutput("abort idle after reset", 8'(obsIdle), 8'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            checkOutput($sformatf("abort line quiet %0d", i), 8'(obsSerial), 8'd1);
        end
        checkOutput("abort idle at end", 8'(obsIdle), 8'd1);

        runFrame(1, 8'h00, 4, 1, "extraStop00");
        runFrame(2, 8'h81, 2, 0, "fast81");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
